prod_acc: RTL and testbench



---
 rtl/prod_acc_if.sv | 39 +++
 rtl/prod_acc.sv | 210 +++++++++++++++++++++
 tb/tb_prod_acc.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/prod_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : prod_acc_if
//  Description : Bundle of the product input side and the result output side
//                of prod_acc. The master modport belongs to whoever drives
//                products and consumes results. The slave modport belongs to
//                prod_acc.
//  Signals     : prod_is_signed, clear, num_terms, prod, prod_valid,
//                acc_ready (master -> slave);
//                acc_out, acc_valid, busy, drop (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface prod_acc_if #(
    parameter int BW_PROD = 7,
    parameter int BW_N    = 3,
    parameter int BW_OUT  = 8
);
    logic               prod_is_signed;
    logic               clear;
    logic [BW_N-1:0]    num_terms;
    logic [BW_PROD-1:0] prod;
    logic               prod_valid;
    logic               acc_ready;
    logic [BW_OUT-1:0]  acc_out;
    logic               acc_valid;
    logic               busy;
    logic               drop;

    modport master (
        output prod_is_signed, clear, num_terms, prod, prod_valid, acc_ready,
        input  acc_out, acc_valid, busy, drop
    );

    modport slave (
        input  prod_is_signed, clear, num_terms, prod, prod_valid, acc_ready,
        output acc_out, acc_valid, busy, drop
    );
endinterface
`default_nettype wire

// File: rtl/prod_acc.sv
`default_nettype none
// ============================================================================
//  Module      : prod_acc
//  Description : Accumulates a programmable number of products from the
//                sequential multiplier. The sum is scaled by a rounding right
//                shift and the result is offered on a valid/ready output.
//                The block never stalls the multiplier. A product that
//                arrives while a result is still pending is dropped, and the
//                sticky drop flag is set.
//  Ports       : clk, rst     - clock and synchronous active-high reset
//                bus (slave)  - product input, control, and result output
//                               (see prod_acc_if)
//  Options     : PROD_ACC_SAT_EN - when defined, the result saturates to the
//                BW_OUT range. When undefined, the result wraps to its low
//                BW_OUT bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module prod_acc #(
    parameter int BW_PROD = 7,
    parameter int BW_ACC  = 10,
    parameter int BW_N    = 3,
    parameter int BW_OUT  = 8,
    parameter int SHIFT   = 1
) (
    input  wire        clk,
    input  wire        rst,
    prod_acc_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [BW_ACC-1:0]   r_acc;
    logic [BW_N:0]       r_cnt;      // one extra bit so 2^BW_N terms can be counted
    logic [BW_N:0]       r_terms;
    logic                r_signed;
    logic [BW_OUT-1:0]   r_acc_out;
    logic                r_drop;

    // Datapath control decoded by the FSM
    logic                w_start;    // product opens a new batch
    logic                w_accum;    // product is added to a running batch
    logic                w_last;     // this product completes the batch
    logic                w_drop;     // product is discarded

    logic                w_sgn;
    logic [BW_ACC-1:0]   w_ext;
    logic [BW_ACC-1:0]   w_sum;
    logic [BW_ACC:0]     w_sum_ext;
    logic [BW_ACC:0]     w_r;
    logic [BW_OUT-1:0]   w_out;
    logic [BW_N:0]       w_terms_in;
    logic [BW_N:0]       w_cnt_inc;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // A new batch uses the live sign mode. A running batch uses the mode
    // latched on its first term.
    assign w_sgn      = (r_state == S_ACC) ? r_signed : bus.prod_is_signed;
    assign w_ext      = w_sgn ? BW_ACC'($signed(bus.prod)) : BW_ACC'(bus.prod);
    assign w_sum      = (r_state == S_ACC) ? (r_acc + w_ext) : w_ext;
    assign w_sum_ext  = w_sgn ? (BW_ACC+1)'($signed(w_sum)) : (BW_ACC+1)'(w_sum);
    assign w_terms_in = (bus.num_terms == '0) ? {1'b1, {BW_N{1'b0}}}
                                              : {1'b0, bus.num_terms};
    assign w_cnt_inc  = r_cnt + (BW_N+1)'(1);

    // Round half up. The extra top bit keeps the rounding add from
    // overflowing.
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [BW_ACC:0] c_HALF = (BW_ACC+1)'(1) << (SHIFT - 1);
            logic        [BW_ACC:0] w_rnd;
            logic signed [BW_ACC:0] w_rnd_s;
            assign w_rnd   = w_sum_ext + c_HALF;
            assign w_rnd_s = $signed(w_rnd);
            assign w_r     = w_sgn ? $unsigned(w_rnd_s >>> SHIFT) : (w_rnd >> SHIFT);
        end else begin : g_no_round
            assign w_r = w_sum_ext;
        end
    endgenerate

`ifdef PROD_ACC_SAT_EN
    // Saturate to the BW_OUT range. A signed value fits when every bit
    // from BW_OUT-1 up to the top bit has the same value.
    logic [BW_ACC-BW_OUT+1:0] w_hi_s;
    logic [BW_ACC-BW_OUT:0]   w_hi_u;
    assign w_hi_s = w_r[BW_ACC:BW_OUT-1];
    assign w_hi_u = w_r[BW_ACC:BW_OUT];

    always_comb begin
        w_out = w_r[BW_OUT-1:0];
        if (w_sgn) begin
            if (!((&w_hi_s) || !(|w_hi_s))) begin
                w_out = w_r[BW_ACC] ? {1'b1, {(BW_OUT-1){1'b0}}}
                                    : {1'b0, {(BW_OUT-1){1'b1}}};
            end
        end else if (|w_hi_u) begin
            w_out = {BW_OUT{1'b1}};
        end
    end
`else
    assign w_out = BW_OUT'(w_r);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accum     = 1'b0;
        w_last      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.prod_valid) begin
                    w_start = 1'b1;
                end
            end
            S_ACC: begin
                if (bus.prod_valid) begin
                    w_accum = 1'b1;
                    if (w_cnt_inc == r_terms) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.acc_ready) begin
                    // The handshake completes. A product arriving in the
                    // same cycle is handed straight to a new batch.
                    w_state_nxt = S_IDLE;
                    if (bus.prod_valid) begin
                        w_start = 1'b1;
                    end
                end else if (bus.prod_valid) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt = (bus.num_terms == BW_N'(1)) ? S_HOLD : S_ACC;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_terms   <= '0;
            r_signed  <= 1'b0;
            r_acc_out <= '0;
            r_drop    <= 1'b0;
        end else begin
            if (w_start) begin
                r_acc    <= w_ext;
                r_terms  <= w_terms_in;
                r_signed <= bus.prod_is_signed;
                r_cnt    <= (BW_N+1)'(1);
                if (bus.num_terms == BW_N'(1)) begin
                    r_acc_out <= w_out;
                end
            end
            if (w_accum) begin
                r_cnt <= w_cnt_inc;
                if (w_last) begin
                    r_acc_out <= w_out;
                end else begin
                    r_acc <= w_sum;
                end
            end
            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign bus.acc_out   = r_acc_out;
    assign bus.acc_valid = (r_state == S_HOLD);
    assign bus.busy      = (r_state == S_ACC);
    assign bus.drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_prod_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prod_acc
//  Description : Directed self-checking bench for prod_acc with default
//                parameters. The expected value for the saturating case
//                follows PROD_ACC_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prod_acc;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    prod_acc_if #(.BW_PROD(7), .BW_N(3), .BW_OUT(8)) bus ();

    prod_acc #(
        .BW_PROD (7),
        .BW_ACC  (10),
        .BW_N    (3),
        .BW_OUT  (8),
        .SHIFT   (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [6:0] p);
        bus.prod       = p;
        bus.prod_valid = 1'b1;
        tick();
        bus.prod_valid = 1'b0;
    endtask

    localparam logic [7:0] c_SAT_EXP =
`ifdef PROD_ACC_SAT_EN
        8'h7F;
`else
        8'hFC;
`endif

    initial begin
        n_err = 0;
        n_chk = 0;
        rst                = 1'b1;
        bus.prod_is_signed = 1'b0;
        bus.clear          = 1'b0;
        bus.num_terms      = 3'd0;
        bus.prod           = 7'd0;
        bus.prod_valid     = 1'b0;
        bus.acc_ready      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_acc_valid", 32'(bus.acc_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_drop",      32'(bus.drop),      32'd0);
        chk("rst_acc_out",   32'(bus.acc_out),   32'd0);

        // Unsigned, 3 terms: 10+20+30=60, (60+1)>>1=30. num_terms changes
        // mid-batch and must be ignored.
        bus.num_terms = 3'd3;
        strobe(7'd10);
        chk("t1_busy_1", 32'(bus.busy), 32'd1);
        bus.num_terms = 3'd1;
        strobe(7'd20);
        chk("t1_busy_2",  32'(bus.busy),      32'd1);
        chk("t1_valid_2", 32'(bus.acc_valid), 32'd0);
        strobe(7'd30);
        chk("t1_valid", 32'(bus.acc_valid), 32'd1);
        chk("t1_out",   32'(bus.acc_out),   32'd30);
        chk("t1_busy3", 32'(bus.busy),      32'd0);
        tick();
        chk("t1_valid_off", 32'(bus.acc_valid), 32'd0);

        // Signed, 2 terms: -5 + -4 = -9, (-9+1)>>>1 = -4
        bus.prod_is_signed = 1'b1;
        bus.num_terms      = 3'd2;
        strobe(7'h7B);
        strobe(7'h7C);
        chk("t2_valid", 32'(bus.acc_valid), 32'd1);
        chk("t2_out",   32'(bus.acc_out),   32'h0FC);
        tick();

        // HOLD with backpressure: 1-term batch of 9 gives (9+1)>>1=5
        bus.prod_is_signed = 1'b0;
        bus.num_terms      = 3'd1;
        bus.acc_ready      = 1'b0;
        strobe(7'd9);
        chk("t3_valid", 32'(bus.acc_valid), 32'd1);
        chk("t3_out",   32'(bus.acc_out),   32'd5);
        tick();
        tick();
        strobe(7'd100);
        chk("t3_drop",     32'(bus.drop),      32'd1);
        chk("t3_out_hold", 32'(bus.acc_out),   32'd5);
        tick();
        tick();
        chk("t3_out_5cyc",   32'(bus.acc_out),   32'd5);
        chk("t3_valid_5cyc", 32'(bus.acc_valid), 32'd1);
        bus.acc_ready = 1'b1;
        tick();
        chk("t3_valid_rel", 32'(bus.acc_valid), 32'd0);
        chk("t3_drop_keep", 32'(bus.drop),      32'd1);

        // Clear after 1 of 3 terms, then a fresh batch 1+2+3=6 gives 3
        bus.num_terms = 3'd3;
        strobe(7'd50);
        chk("t4_busy", 32'(bus.busy), 32'd1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("t4_busy_clr", 32'(bus.busy), 32'd0);
        chk("t4_drop_clr", 32'(bus.drop), 32'd0);
        strobe(7'd1);
        strobe(7'd2);
        strobe(7'd3);
        chk("t4_valid", 32'(bus.acc_valid), 32'd1);
        chk("t4_out",   32'(bus.acc_out),   32'd3);
        chk("t4_drop",  32'(bus.drop),      32'd0);
        tick();

        // Signed, 8 terms of 63: 504, r=252 -> saturates or wraps
        bus.prod_is_signed = 1'b1;
        bus.num_terms      = 3'd0;
        for (int i = 0; i < 7; i++) begin
            strobe(7'd63);
        end
        chk("t5_busy7",  32'(bus.busy),      32'd1);
        chk("t5_valid7", 32'(bus.acc_valid), 32'd0);
        strobe(7'd63);
        chk("t5_valid", 32'(bus.acc_valid), 32'd1);
        chk("t5_out",   32'(bus.acc_out),   32'(c_SAT_EXP));
        tick();

        // Handoff in HOLD: first result (20+1)>>1=10, then (5+1)>>1=3
        bus.prod_is_signed = 1'b0;
        bus.num_terms      = 3'd1;
        bus.acc_ready      = 1'b0;
        strobe(7'd20);
        chk("t6_out1", 32'(bus.acc_out), 32'd10);
        bus.acc_ready = 1'b1;
        strobe(7'd5);
        chk("t6_valid2", 32'(bus.acc_valid), 32'd1);
        chk("t6_out2",   32'(bus.acc_out),   32'd3);
        chk("t6_drop",   32'(bus.drop),      32'd0);
        tick();
        chk("t6_valid_off", 32'(bus.acc_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
